// File: rtl/pong_pkg.sv
// Shared definitions for the paddle game: FSM states, round-winner codes and
// the default screen geometry also used by the VGA controller.
package pong_pkg;

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} state_t;

  typedef enum logic [2:0] {NONE = 3'd0, P1 = 3'd1, P2 = 3'd2} winner_t;

  localparam int BALL_HALF_W  = 10;
  localparam int BALL_HALF_H  = 15;
  localparam int GOAL_TOP_DEF = 200;
  localparam int GOAL_BOT_DEF = 280;
  localparam int SCR_X_MIN    = 10;
  localparam int SCR_X_MAX    = 628;
  localparam int SCR_Y_MIN    = 15;
  localparam int SCR_Y_MAX    = 463;

endpackage

// File: rtl/box_overlap.sv
// Combinational strict-inequality overlap test between a box centred at
// (cx,cy) with the given half sizes and an exclusive-bound rectangle.
module box_overlap #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] cx,
  input  logic signed [W-1:0] cy,
  input  logic signed [W-1:0] halfW,
  input  logic signed [W-1:0] halfH,
  input  logic signed [W-1:0] left,
  input  logic signed [W-1:0] right,
  input  logic signed [W-1:0] top,
  input  logic signed [W-1:0] bottom,
  output logic                hit
);

  always_comb begin
    hit = ((cx - halfW) < right) && ((cx + halfW) > left) &&
          ((cy - halfH) < bottom) && ((cy + halfH) > top);
  end

endmodule

// File: rtl/ball_engine.sv
// Per-frame ball motion, wall/paddle bounces, goal detection and scoring.
// Everything advances only on a sampled frame_tick; outputs are registered.
module ball_engine
  import pong_pkg::*;
#(
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int X_MIN        = SCR_X_MIN,
  parameter int X_MAX        = SCR_X_MAX,
  parameter int Y_MIN        = SCR_Y_MIN,
  parameter int Y_MAX        = SCR_Y_MAX,
  parameter int HALF_W       = BALL_HALF_W,
  parameter int HALF_H       = BALL_HALF_H,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 1,
  parameter int GOAL_TOP     = GOAL_TOP_DEF,
  parameter int GOAL_BOT     = GOAL_BOT_DEF,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 90,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] p1_left,
  input  logic [9:0] p1_right,
  input  logic [8:0] p1_top,
  input  logic [8:0] p1_bottom,
  input  logic [9:0] p2_left,
  input  logic [9:0] p2_right,
  input  logic [8:0] p2_top,
  input  logic [8:0] p2_bottom,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [2:0] winner,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over
);

  localparam int CNT_W = 16;
  localparam logic signed [10:0] SPX  = 11'(SPEED_X);
  localparam logic signed [10:0] SPY  = 11'(SPEED_Y);
  localparam logic signed [10:0] XMN  = 11'(X_MIN);
  localparam logic signed [10:0] XMX  = 11'(X_MAX);
  localparam logic signed [10:0] YMN  = 11'(Y_MIN);
  localparam logic signed [10:0] YMX  = 11'(Y_MAX);
  localparam logic signed [10:0] GTOP = 11'(GOAL_TOP);
  localparam logic signed [10:0] GBOT = 11'(GOAL_BOT);

  function automatic logic [3:0] satInc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   frameCnt;
  logic               dxRight;
  logic               dyDown;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic [8:0]         yNext;
  logic               dyNext;
  logic               hitP1;
  logic               hitP2;
  logic               paddleHit;
  logic               goalRow;
  logic               serveDone;
  logic               holdDone;

  // Candidate position: 11-bit signed so steps past either edge never wrap
  always_comb begin
    nx = dxRight ? signed'({1'b0, ball_x}) + SPX : signed'({1'b0, ball_x}) - SPX;
    ny = dyDown  ? signed'({2'b0, ball_y}) + SPY : signed'({2'b0, ball_y}) - SPY;
    yNext  = ny[8:0];
    dyNext = dyDown;
    if (ny <= YMN) begin
      yNext  = 9'(Y_MIN);
      dyNext = 1'b1;
    end else if (ny >= YMX) begin
      yNext  = 9'(Y_MAX);
      dyNext = 1'b0;
    end
    goalRow   = (ny > GTOP) && (ny < GBOT);
    paddleHit = dxRight ? hitP2 : hitP1;
    serveDone = (frameCnt == CNT_W'(SERVE_FRAMES - 1));
    holdDone  = (frameCnt == CNT_W'(HOLD_FRAMES - 1));
  end

  box_overlap #(.W(12)) p1Box (
    .cx(12'({nx[10], nx})), .cy(12'({ny[10], ny})),
    .halfW(12'(HALF_W)), .halfH(12'(HALF_H)),
    .left({2'b0, p1_left}), .right({2'b0, p1_right}),
    .top({3'b0, p1_top}), .bottom({3'b0, p1_bottom}),
    .hit(hitP1)
  );

  box_overlap #(.W(12)) p2Box (
    .cx(12'({nx[10], nx})), .cy(12'({ny[10], ny})),
    .halfW(12'(HALF_W)), .halfH(12'(HALF_H)),
    .left({2'b0, p2_left}), .right({2'b0, p2_right}),
    .top({3'b0, p2_top}), .bottom({3'b0, p2_bottom}),
    .hit(hitP2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SERVE;
      frameCnt  <= '0;
      dxRight   <= 1'b1;
      dyDown    <= 1'b1;
      ball_x    <= 10'(X_INIT);
      ball_y    <= 9'(Y_INIT);
      winner    <= NONE;
      p1_score  <= 4'd0;
      p2_score  <= 4'd0;
      game_over <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        SERVE: begin
          if (serveDone) begin
            state    <= PLAY;
            frameCnt <= '0;
          end else begin
            frameCnt <= frameCnt + 1'b1;
          end
        end
        PLAY: begin
          ball_y <= yNext;
          dyDown <= dyNext;
          // A paddle hit outranks any wall or goal on the same step
          if (paddleHit) begin
            dxRight <= ~dxRight;
          end else if (nx <= XMN) begin
            ball_x <= 10'(X_MIN);
            if (goalRow) begin
              p2_score <= satInc(p2_score);
              winner   <= P2;
              state    <= SCORED;
              frameCnt <= '0;
            end else begin
              dxRight <= 1'b1;
            end
          end else if (nx >= XMX) begin
            ball_x <= 10'(X_MAX);
            if (goalRow) begin
              p1_score <= satInc(p1_score);
              winner   <= P1;
              state    <= SCORED;
              frameCnt <= '0;
            end else begin
              dxRight <= 1'b0;
            end
          end else begin
            ball_x <= nx[9:0];
          end
        end
        SCORED: begin
          if (holdDone) begin
            frameCnt <= '0;
            if (p1_score == 4'(WIN_SCORE) || p2_score == 4'(WIN_SCORE)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              // Serve toward whoever conceded the last goal
              state   <= SERVE;
              dxRight <= (winner == P1);
              winner  <= NONE;
              ball_x  <= 10'(X_INIT);
              ball_y  <= 9'(Y_INIT);
            end
          end else begin
            frameCnt <= frameCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: two instances (default and SPEED_Y=0)
// checked every frame against a plain-integer model of the game rules.
module tb_ball_engine;

  localparam int M_SERVE = 0, M_PLAY = 1, M_SCORED = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] p1L, p1R, p2L, p2R;
  logic [8:0] p1T, p1B, p2T, p2B;
  logic [9:0] bx[2];
  logic [8:0] by[2];
  logic [2:0] win[2];
  logic [3:0] s1[2];
  logic [3:0] s2[2];
  logic       go[2];

  int nCompared = 0;
  int nMismatched = 0;

  int mSt[2], mCnt[2], mX[2], mY[2], mDx[2], mDy[2], mWin[2], mS1[2], mS2[2];
  int speedY[2] = '{1, 0};
  int tl1, tr1, tt1, tb1, tl2, tr2, tt2, tb2;

  always #5 clk = ~clk;

  ball_engine dutA (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .p1_left(p1L), .p1_right(p1R), .p1_top(p1T), .p1_bottom(p1B),
    .p2_left(p2L), .p2_right(p2R), .p2_top(p2T), .p2_bottom(p2B),
    .ball_x(bx[0]), .ball_y(by[0]), .winner(win[0]),
    .p1_score(s1[0]), .p2_score(s2[0]), .game_over(go[0])
  );

  ball_engine #(.SPEED_Y(0)) dutB (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .p1_left(p1L), .p1_right(p1R), .p1_top(p1T), .p1_bottom(p1B),
    .p2_left(p2L), .p2_right(p2R), .p2_top(p2T), .p2_bottom(p2B),
    .ball_x(bx[1]), .ball_y(by[1]), .winner(win[1]),
    .p1_score(s1[1]), .p2_score(s2[1]), .game_over(go[1])
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampI(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit overlaps(input int cx, input int cy, input int l,
                                  input int r, input int t, input int b);
    return (cx - 10 < r) && (cx + 10 > l) && (cy - 15 < b) && (cy + 15 > t);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mSt[k] = M_SERVE; mCnt[k] = 0; mX[k] = 320; mY[k] = 240;
      mDx[k] = 1; mDy[k] = 1; mWin[k] = 0; mS1[k] = 0; mS2[k] = 0;
    end
  endtask

  task automatic stepModel(input int k);
    int nx, ny;
    bit hit;
    case (mSt[k])
      M_SERVE: begin
        mCnt[k]++;
        if (mCnt[k] == 60) begin mSt[k] = M_PLAY; mCnt[k] = 0; end
      end
      M_PLAY: begin
        nx = mX[k] + 2 * mDx[k];
        ny = mY[k] + speedY[k] * mDy[k];
        if (ny <= 15) begin mY[k] = 15; mDy[k] = 1; end
        else if (ny >= 463) begin mY[k] = 463; mDy[k] = -1; end
        else mY[k] = ny;
        hit = (mDx[k] < 0) ? overlaps(nx, ny, tl1, tr1, tt1, tb1)
                           : overlaps(nx, ny, tl2, tr2, tt2, tb2);
        if (hit) mDx[k] = -mDx[k];
        else if (nx <= 10 || nx >= 628) begin
          mX[k] = (nx <= 10) ? 10 : 628;
          if (ny > 200 && ny < 280) begin
            if (nx <= 10) begin mS2[k] = (mS2[k] < 15) ? mS2[k] + 1 : 15; mWin[k] = 2; end
            else          begin mS1[k] = (mS1[k] < 15) ? mS1[k] + 1 : 15; mWin[k] = 1; end
            mSt[k] = M_SCORED; mCnt[k] = 0;
          end else begin
            mDx[k] = (nx <= 10) ? 1 : -1;
          end
        end else mX[k] = nx;
      end
      M_SCORED: begin
        mCnt[k]++;
        if (mCnt[k] == 90) begin
          mCnt[k] = 0;
          if (mS1[k] == 7 || mS2[k] == 7) mSt[k] = M_OVER;
          else begin
            mSt[k] = M_SERVE; mDx[k] = (mWin[k] == 2) ? -1 : 1;
            mWin[k] = 0; mX[k] = 320; mY[k] = 240;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      checkVal($sformatf("ball_x[%0d]", k), int'(bx[k]), mX[k]);
      checkVal($sformatf("ball_y[%0d]", k), int'(by[k]), mY[k]);
      checkVal($sformatf("winner[%0d]", k), int'(win[k]), mWin[k]);
      checkVal($sformatf("p1_score[%0d]", k), int'(s1[k]), mS1[k]);
      checkVal($sformatf("p2_score[%0d]", k), int'(s2[k]), mS2[k]);
      checkVal($sformatf("game_over[%0d]", k), int'(go[k]), int'(mSt[k] == M_OVER));
    end
  endtask

  task automatic drivePaddles();
    p1L = 10'(tl1); p1R = 10'(tr1); p1T = 9'(tt1); p1B = 9'(tb1);
    p2L = 10'(tl2); p2R = 10'(tr2); p2T = 9'(tt2); p2B = 9'(tb2);
  endtask

  // Far paddles never touch the ball; a near box is centred loosely on one ball
  task automatic pickPaddles(input bit allowNear);
    int k;
    tl1 = $urandom_range(700, 1000); tr1 = tl1 + 10;
    tt1 = $urandom_range(0, 400);    tb1 = tt1 + 60;
    tl2 = $urandom_range(700, 1000); tr2 = tl2 + 10;
    tt2 = $urandom_range(0, 400);    tb2 = tt2 + 60;
    if (allowNear && ($urandom_range(0, 399) == 0)) begin
      k = $urandom_range(0, 1);
      tl1 = clampI(mX[k] - $urandom_range(0, 40), 0, 1023);
      tr1 = clampI(mX[k] + $urandom_range(1, 40), 0, 1023);
      tt1 = clampI(mY[k] - $urandom_range(0, 40), 0, 511);
      tb1 = clampI(mY[k] + $urandom_range(1, 40), 0, 511);
      tl2 = tl1; tr2 = tr1; tt2 = tt1; tb2 = tb1;
    end
  endtask

  task automatic doTick(input bit withReset, input bit allowNear);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      p1L = 10'($urandom); p1R = 10'($urandom); p1T = 9'($urandom); p1B = 9'($urandom);
      p2L = 10'($urandom); p2R = 10'($urandom); p2T = 9'($urandom); p2B = 9'($urandom);
    end
    @(negedge clk);
    pickPaddles(allowNear);
    drivePaddles();
    frame_tick = 1'b1;
    reset = withReset;
    @(negedge clk);
    frame_tick = 1'b0;
    reset = 1'b0;
    if (withReset) modelReset();
    else begin
      stepModel(0);
      stepModel(1);
    end
    checkAll();
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b1;
    pickPaddles(1'b0);
    drivePaddles();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    modelReset();
    checkVal("rst_ball_x", int'(bx[0]), 320);
    checkVal("rst_ball_y", int'(by[0]), 240);
    checkVal("rst_winner", int'(win[0]), 0);
    checkVal("rst_game_over", int'(go[0]), 0);
    checkAll();

    for (int i = 0; i < 59; i++) doTick(1'b0, 1'b0);
    checkVal("serve59_x", int'(bx[0]), 320);
    doTick(1'b0, 1'b0);
    checkVal("serve60_x", int'(bx[0]), 320);
    doTick(1'b0, 1'b0);
    checkVal("first_step_x", int'(bx[0]), 322);
    checkVal("first_step_y", int'(by[0]), 241);
    checkVal("first_step_yB", int'(by[1]), 240);

    for (int i = 0; i < 6000; i++) doTick(i == 200, 1'b1);
    checkVal("game_over_reached", int'(go[1]), 1);

    for (int i = 0; i < 5; i++) doTick(1'b0, 1'b0);
    doTick(1'b1, 1'b0);
    checkVal("tick_reset_x", int'(bx[1]), 320);
    checkVal("tick_reset_score", int'(s1[1]), 0);
    checkVal("tick_reset_over", int'(go[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
